sim_check_sequencer: RTL and testbench
======================================

Name: sim_check_sequencer

Overview:
Parametrised simulation-control block for generated test harnesses. It supersedes the single-condition "finish after reset" harness. It collects pass/fail checks from NUM_CH channels, counts cycles, enforces a timeout, and drains for a fixed number of cycles before declaring a verdict. The verdict is exposed as status outputs. Under an optional macro it also ends the simulation.

Parameters:
NUM_CH, 4, number of independent check channels (1..32)
CNT_W, 16, width of cycle and check counters
TIMEOUT, 1000, RUN-state cycles before a timeout verdict (1..2^CNT_W-1)
DRAIN_CYCLES, 2, cycles spent in DRAIN before DONE (0..15)
MAX_ERRORS, 1, error count that forces early termination (1..255)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low; all state cleared on the clock edge where reset=0
start  in  1  1-cycle pulse; begins a run from IDLE
chk_valid  in  NUM_CH  per-channel check strobe
chk_pass  in  NUM_CH  per-channel result; qualified by chk_valid
done_req  in  1  stimulus requests end of test
busy  out  1  high in RUN or DRAIN
finished  out  1  high in DONE
passed  out  1  verdict, valid when finished
failed  out  1  verdict, valid when finished
timed_out  out  1  sticky; timeout occurred
cycle_count  out  CNT_W  cycles spent in RUN+DRAIN, saturating
check_count  out  CNT_W  total qualified checks, saturating
error_count  out  8  total failed checks, saturating at 255
first_fail_ch  out  max(1,$clog2(NUM_CH))  lowest failing channel index in the first failing cycle

Behaviour:
- Reset (reset=0 at clock edge):
  - state=IDLE.
  - All outputs 0: busy, finished, passed, failed, timed_out, all counters, first_fail_ch.
  - Reset mid-run aborts with no verdict.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered; no combinational input-to-output paths.
- IDLE:
  - start=1 -> RUN on the next edge.
  - Counters are already 0.
  - chk_valid and done_req are ignored.
- RUN / DRAIN, per cycle:
  - cycle_count += 1 (saturating).
  - n_ok = popcount(chk_valid).
  - n_err = popcount(chk_valid & ~chk_pass).
  - check_count += n_ok (saturating at 2^CNT_W-1).
  - error_count += n_err (saturating at 255).
  - On the first cycle with n_err>0: first_fail_ch = lowest set index of (chk_valid & ~chk_pass). It is never updated afterwards.
- RUN exits, priority highest first; all are evaluated on the same edge:
  - (1) error_count_next >= MAX_ERRORS -> DRAIN.
  - (2) done_req=1 -> DRAIN.
  - (3) cycle_count_next == TIMEOUT -> DRAIN, set timed_out.
  - Otherwise stay in RUN.
  - Errors arriving in the same cycle as done_req or a timeout are still counted.
- DRAIN:
  - Lasts exactly DRAIN_CYCLES cycles, then DONE.
  - DRAIN_CYCLES=0 goes RUN -> DONE directly.
  - Checks keep being counted; done_req is ignored.
- DONE:
  - finished=1, busy=0, counters frozen.
  - passed = (error_count==0) & ~timed_out & (check_count!=0).
  - failed = ~passed.
  - passed and failed are registered and change on the same edge as finished.
  - Only reset leaves DONE; start is ignored.
- start while in RUN or DRAIN: ignored.
- Zero checks seen: failed=1 even if done_req arrived cleanly. An empty test is a failure.

Optional Feature:
Macro SIM_CHECK_FINISH_EN.
- Defined: in non-synthesis builds, on the edge entering DONE the block prints one line containing PASS/FAIL, cycle_count, check_count, error_count and first_fail_ch, then calls $finish. This happens only when STOP_COND is undefined or true.
- Undefined: no system tasks; status outputs only. This is the synthesisable default.

Test Plan:
- Reset held 3 cycles, then reset=1 with no start for 10 cycles -> state IDLE, all outputs 0, cycle_count=0.
- start; chk_valid=4'b0001, chk_pass=4'b0001 for 5 cycles; done_req on cycle 6, DRAIN_CYCLES=2 -> finished 3 edges after done_req; passed=1, check_count=5, error_count=0, cycle_count=8.
- start; cycle 3: chk_valid=4'b1010, chk_pass=4'b1000, MAX_ERRORS=1 -> first_fail_ch=1, error_count=1, DRAIN entered; DONE with failed=1.
- start; no done_req, TIMEOUT=20 -> timed_out=1 after 20 RUN cycles; finished after DRAIN; failed=1.
- Same cycle: done_req=1 and chk_valid=4'b0100, chk_pass=0, MAX_ERRORS=3 -> error_count=1, DRAIN entered, final failed=1.
- Mid-RUN at cycle 7, drive reset=0 for 1 cycle -> next edge: IDLE with all outputs 0; a new start then produces a fresh run from cycle_count=0.

Source files
------------

// File: rtl/sim_check_sequencer_if.sv
// sim_check_sequencer_if: stimulus-side bundle for sim_check_sequencer.
// Carries the run control (start, done_req) and the per-channel check strobes.
// master drives the bundle (test harness), slave receives it (sequencer).
interface sim_check_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              start;
  logic [NUM_CH-1:0] chk_valid;
  logic [NUM_CH-1:0] chk_pass;
  logic              done_req;

  modport master (output start, output chk_valid, output chk_pass, output done_req);
  modport slave  (input  start, input  chk_valid, input  chk_pass, input  done_req);
endinterface

// File: rtl/sim_check_sequencer.sv
// sim_check_sequencer: collects pass/fail checks from NUM_CH channels, counts
// RUN+DRAIN cycles, enforces a timeout and drains before a registered verdict.
// Optional macro SIM_CHECK_FINISH_EN: in non-synthesis builds, print a verdict
// line and call $finish on entry to DONE (gated by STOP_COND when defined).
// Default build (macro undefined) has status outputs only.
module sim_check_sequencer #(
  parameter  int NUM_CH       = 4,
  parameter  int CNT_W        = 16,
  parameter  int TIMEOUT      = 1000,
  parameter  int DRAIN_CYCLES = 2,
  parameter  int MAX_ERRORS   = 1,
  localparam int FW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sim_check_sequencer_if.slave chk_if,
  output logic                 busy,
  output logic                 finished,
  output logic                 passed,
  output logic                 failed,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     check_count,
  output logic [7:0]           error_count,
  output logic [FW-1:0]        first_fail_ch
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [7:0]       MAX_ERR_C  = 8'(MAX_ERRORS);
  // DRAIN counts down to zero, so load one less than the cycle count.
  localparam logic [3:0]       DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  function automatic logic [5:0] popcount(input logic [NUM_CH-1:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [FW-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    logic [FW-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = FW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              passed_q, passed_d;
  logic              failed_q, failed_d;
  logic              timed_out_q, timed_out_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  check_q, check_d;
  logic [7:0]        err_q, err_d;
  logic [FW-1:0]     ffc_q, ffc_d;

  logic [NUM_CH-1:0] fail_vec_s;
  logic [5:0]        n_ok_s, n_err_s;
  logic [CNT_W:0]    cyc_sum_s, chk_sum_s;
  logic [8:0]        err_sum_s;
  logic [CNT_W-1:0]  cyc_sat_s, chk_sat_s;
  logic [7:0]        err_sat_s;
  logic              good_s;

  // Per-cycle saturating accumulation candidates, used in RUN and DRAIN.
  always_comb begin
    fail_vec_s = chk_if.chk_valid & ~chk_if.chk_pass;
    n_ok_s     = popcount(chk_if.chk_valid);
    n_err_s    = popcount(fail_vec_s);
    cyc_sum_s  = {1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1};
    chk_sum_s  = {1'b0, check_q} + (CNT_W+1)'(n_ok_s);
    err_sum_s  = {1'b0, err_q} + {3'd0, n_err_s};
    cyc_sat_s  = cyc_sum_s[CNT_W] ? CNT_MAX : cyc_sum_s[CNT_W-1:0];
    chk_sat_s  = chk_sum_s[CNT_W] ? CNT_MAX : chk_sum_s[CNT_W-1:0];
    err_sat_s  = err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
  end

  // Next-state, counter and verdict computation.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cycle_d     = cycle_q;
    check_d     = check_q;
    err_d       = err_q;
    ffc_d       = ffc_q;
    timed_out_d = timed_out_q;
    passed_d    = passed_q;
    failed_d    = failed_q;
    good_s      = 1'b0;

    if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
      cycle_d = cyc_sat_s;
      check_d = chk_sat_s;
      err_d   = err_sat_s;
      // first_fail_ch latches only on the first cycle that carries an error.
      if ((err_q == 8'd0) && (n_err_s != 6'd0)) begin
        ffc_d = lowest_idx(fail_vec_s);
      end else begin
        ffc_d = ffc_q;
      end
    end else begin
      cycle_d = cycle_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (chk_if.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((err_sat_s >= MAX_ERR_C) || chk_if.done_req || (cyc_sat_s == TIMEOUT_C)) begin
          // The timeout flag is set only when it is the winning exit.
          if (!(err_sat_s >= MAX_ERR_C) && !chk_if.done_req) begin
            timed_out_d = 1'b1;
          end else begin
            timed_out_d = timed_out_q;
          end
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Verdict is captured on the edge that enters DONE, from the final counts.
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      good_s   = (err_d == 8'd0) && !timed_out_d && (check_d != '0);
      passed_d = good_s;
      failed_d = !good_s;
    end else begin
      passed_d = passed_q;
      failed_d = failed_q;
    end

    busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    finished_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= 4'd0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timed_out_q <= 1'b0;
      cycle_q     <= '0;
      check_q     <= '0;
      err_q       <= 8'd0;
      ffc_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      timed_out_q <= timed_out_d;
      cycle_q     <= cycle_d;
      check_q     <= check_d;
      err_q       <= err_d;
      ffc_q       <= ffc_d;
    end
  end

  assign busy          = busy_q;
  assign finished      = finished_q;
  assign passed        = passed_q;
  assign failed        = failed_q;
  assign timed_out     = timed_out_q;
  assign cycle_count   = cycle_q;
  assign check_count   = check_q;
  assign error_count   = err_q;
  assign first_fail_ch = ffc_q;

`ifdef SIM_CHECK_FINISH_EN
`ifndef SYNTHESIS
`ifndef STOP_COND
`define STOP_COND 1'b1
`endif
  // Report the verdict and end the simulation on the edge entering DONE.
  always @(posedge clock) begin
    if (reset && (state_q != ST_DONE) && (state_d == ST_DONE)) begin
      if (`STOP_COND) begin
        $display("sim_check_sequencer %s cycle_count=%0d check_count=%0d error_count=%0d first_fail_ch=%0d",
                 good_s ? "PASS" : "FAIL", cycle_d, check_d, err_d, ffc_d);
        $finish;
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_sim_check_sequencer.sv
// tb_sim_check_sequencer: scenario tasks with a verdict scoreboard.
// dut_a uses MAX_ERRORS=1, dut_b uses MAX_ERRORS=3; both share one stimulus bundle.
module tb_sim_check_sequencer;

  typedef struct packed {
    logic        passed;
    logic        failed;
    logic        timed_out;
    logic [15:0] cc;
    logic [15:0] chk;
    logic [7:0]  err;
    logic [1:0]  ffc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        a_busy, a_fin, a_pass, a_fail, a_to;
  logic [15:0] a_cc, a_chk;
  logic [7:0]  a_err;
  logic [1:0]  a_ffc;
  logic        b_busy, b_fin, b_pass, b_fail, b_to;
  logic [15:0] b_cc, b_chk;
  logic [7:0]  b_err;
  logic [1:0]  b_ffc;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t e;
  exp_t o;
  int   edges;

  sim_check_sequencer_if #(.NUM_CH(4)) cif ();

  sim_check_sequencer #(.NUM_CH(4), .CNT_W(16), .TIMEOUT(20), .DRAIN_CYCLES(2), .MAX_ERRORS(1)) dut_a (
    .clock(clock), .reset(reset), .chk_if(cif),
    .busy(a_busy), .finished(a_fin), .passed(a_pass), .failed(a_fail), .timed_out(a_to),
    .cycle_count(a_cc), .check_count(a_chk), .error_count(a_err), .first_fail_ch(a_ffc)
  );

  sim_check_sequencer #(.NUM_CH(4), .CNT_W(16), .TIMEOUT(20), .DRAIN_CYCLES(2), .MAX_ERRORS(3)) dut_b (
    .clock(clock), .reset(reset), .chk_if(cif),
    .busy(b_busy), .finished(b_fin), .passed(b_pass), .failed(b_fail), .timed_out(b_to),
    .cycle_count(b_cc), .check_count(b_chk), .error_count(b_err), .first_fail_ch(b_ffc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t obs_a();
    exp_t r;
    r = '{passed: a_pass, failed: a_fail, timed_out: a_to, cc: a_cc, chk: a_chk, err: a_err, ffc: a_ffc};
    return r;
  endfunction

  function automatic exp_t obs_b();
    exp_t r;
    r = '{passed: b_pass, failed: b_fail, timed_out: b_to, cc: b_cc, chk: b_chk, err: b_err, ffc: b_ffc};
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    cif.start     = 1'b0;
    cif.chk_valid = 4'b0000;
    cif.chk_pass  = 4'b0000;
    cif.done_req  = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Advance until dut_a (or dut_b when use_b) reports finished, bounded.
  task automatic wait_fin(input bit use_b, output int n);
    n = 0;
    while (!(use_b ? b_fin : a_fin) && n < 60) begin
      step();
      n++;
    end
    n_checks++;
    if (!(use_b ? b_fin : a_fin)) begin
      n_fail++;
      $display("FAIL wait_finished actual=0 required=1 after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    // chk_valid/done_req are ignored in IDLE
    cif.chk_valid = 4'b1111;
    cif.done_req  = 1'b1;
    repeat (10) step();
    clear_inputs();
    n_checks++;
    if ({a_busy, a_fin, a_pass, a_fail, a_to} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags actual=%b required=00000", {a_busy, a_fin, a_pass, a_fail, a_to});
    end
    n_checks++;
    if (a_cc !== 16'd0) begin
      n_fail++; $display("FAIL reset_cycle_count actual=%0d required=0", a_cc);
    end
    n_checks++;
    if ({a_chk, a_err, a_ffc} !== 26'd0) begin
      n_fail++; $display("FAIL reset_counters actual=%0d/%0d/%0d required=0/0/0", a_chk, a_err, a_ffc);
    end
    n_checks++;
    if ({b_busy, b_fin, b_cc} !== 18'd0) begin
      n_fail++; $display("FAIL reset_dut_b actual=%b/%b/%0d required=0/0/0", b_busy, b_fin, b_cc);
    end
  endtask

  task automatic test_clean_pass();
    apply_reset();
    cif.start = 1'b1;
    step();
    cif.start = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL pass_busy actual=%b required=1", a_busy);
    end
    for (int i = 0; i < 5; i++) begin
      cif.chk_valid = 4'b0001;
      cif.chk_pass  = 4'b0001;
      cif.start     = (i == 2) ? 1'b1 : 1'b0;
      step();
    end
    clear_inputs();
    cif.done_req = 1'b1;
    exp_q.push_back('{passed: 1'b1, failed: 1'b0, timed_out: 1'b0, cc: 16'd8, chk: 16'd5, err: 8'd0, ffc: 2'd0});
    step();
    cif.done_req = 1'b0;
    n_checks++;
    if (a_cc !== 16'd6 || a_fin !== 1'b0) begin
      n_fail++; $display("FAIL pass_done_edge actual=cc%0d fin%b required=cc6 fin0", a_cc, a_fin);
    end
    wait_fin(1'b0, edges);
    n_checks++;
    if (edges !== 2) begin
      n_fail++; $display("FAIL pass_drain_len actual=%0d required=2", edges);
    end
    e = exp_q.pop_front();
    o = obs_a();
    n_checks++;
    if (o !== e) begin
      n_fail++; $display("FAIL pass_verdict actual=%h required=%h", o, e);
    end
    cif.start = 1'b1;
    step();
    cif.start = 1'b0;
    step();
    n_checks++;
    if (a_fin !== 1'b1 || a_cc !== 16'd8 || a_pass !== 1'b1) begin
      n_fail++; $display("FAIL done_frozen actual=fin%b cc%0d pass%b required=fin1 cc8 pass1", a_fin, a_cc, a_pass);
    end
  endtask

  task automatic test_first_fail();
    apply_reset();
    cif.start = 1'b1;
    step();
    cif.start = 1'b0;
    step();
    step();
    cif.chk_valid = 4'b1010;
    cif.chk_pass  = 4'b1000;
    step();
    n_checks++;
    if (a_err !== 8'd1 || a_ffc !== 2'd1 || a_chk !== 16'd2 || a_cc !== 16'd3) begin
      n_fail++; $display("FAIL ff_counts actual=err%0d ffc%0d chk%0d cc%0d required=err1 ffc1 chk2 cc3", a_err, a_ffc, a_chk, a_cc);
    end
    // a later failure on channel 0 during DRAIN is counted but keeps first_fail_ch
    cif.chk_valid = 4'b0001;
    cif.chk_pass  = 4'b0000;
    exp_q.push_back('{passed: 1'b0, failed: 1'b1, timed_out: 1'b0, cc: 16'd5, chk: 16'd3, err: 8'd2, ffc: 2'd1});
    step();
    clear_inputs();
    wait_fin(1'b0, edges);
    e = exp_q.pop_front();
    o = obs_a();
    n_checks++;
    if (o !== e) begin
      n_fail++; $display("FAIL ff_verdict actual=%h required=%h", o, e);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    cif.start = 1'b1;
    step();
    cif.start     = 1'b0;
    cif.chk_valid = 4'b0001;
    cif.chk_pass  = 4'b0001;
    step();
    clear_inputs();
    exp_q.push_back('{passed: 1'b0, failed: 1'b1, timed_out: 1'b1, cc: 16'd22, chk: 16'd1, err: 8'd0, ffc: 2'd0});
    repeat (18) step();
    n_checks++;
    if (a_to !== 1'b0 || a_cc !== 16'd19) begin
      n_fail++; $display("FAIL to_early actual=to%b cc%0d required=to0 cc19", a_to, a_cc);
    end
    step();
    n_checks++;
    if (a_to !== 1'b1 || a_cc !== 16'd20) begin
      n_fail++; $display("FAIL to_flag actual=to%b cc%0d required=to1 cc20", a_to, a_cc);
    end
    wait_fin(1'b0, edges);
    e = exp_q.pop_front();
    o = obs_a();
    n_checks++;
    if (o !== e) begin
      n_fail++; $display("FAIL to_verdict actual=%h required=%h", o, e);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    cif.start = 1'b1;
    step();
    cif.start     = 1'b0;
    cif.chk_valid = 4'b0001;
    cif.chk_pass  = 4'b0001;
    step();
    cif.done_req  = 1'b1;
    cif.chk_valid = 4'b0100;
    cif.chk_pass  = 4'b0000;
    exp_q.push_back('{passed: 1'b0, failed: 1'b1, timed_out: 1'b0, cc: 16'd4, chk: 16'd2, err: 8'd1, ffc: 2'd2});
    exp_q.push_back('{passed: 1'b0, failed: 1'b1, timed_out: 1'b0, cc: 16'd4, chk: 16'd2, err: 8'd1, ffc: 2'd2});
    step();
    clear_inputs();
    n_checks++;
    if (b_err !== 8'd1 || b_ffc !== 2'd2 || b_busy !== 1'b1) begin
      n_fail++; $display("FAIL same_counts actual=err%0d ffc%0d busy%b required=err1 ffc2 busy1", b_err, b_ffc, b_busy);
    end
    wait_fin(1'b1, edges);
    e = exp_q.pop_front();
    o = obs_b();
    n_checks++;
    if (o !== e) begin
      n_fail++; $display("FAIL same_verdict_b actual=%h required=%h", o, e);
    end
    e = exp_q.pop_front();
    o = obs_a();
    n_checks++;
    if (o !== e || a_fin !== 1'b1) begin
      n_fail++; $display("FAIL same_verdict_a actual=%h fin%b required=%h fin1", o, a_fin, e);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    cif.start = 1'b1;
    step();
    cif.start     = 1'b0;
    cif.chk_valid = 4'b0001;
    cif.chk_pass  = 4'b0001;
    repeat (7) step();
    n_checks++;
    if (a_cc !== 16'd7 || a_chk !== 16'd7) begin
      n_fail++; $display("FAIL mid_progress actual=cc%0d chk%0d required=cc7 chk7", a_cc, a_chk);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    clear_inputs();
    n_checks++;
    if ({a_busy, a_fin, a_pass, a_fail, a_to, a_cc, a_chk, a_err, a_ffc} !== 47'd0) begin
      n_fail++; $display("FAIL mid_reset_clear actual=busy%b cc%0d chk%0d required=busy0 cc0 chk0", a_busy, a_cc, a_chk);
    end
    step();
    n_checks++;
    if (a_busy !== 1'b0 || a_cc !== 16'd0) begin
      n_fail++; $display("FAIL mid_idle actual=busy%b cc%0d required=busy0 cc0", a_busy, a_cc);
    end
    cif.start = 1'b1;
    step();
    cif.start     = 1'b0;
    cif.chk_valid = 4'b0011;
    cif.chk_pass  = 4'b0011;
    step();
    clear_inputs();
    cif.done_req = 1'b1;
    exp_q.push_back('{passed: 1'b1, failed: 1'b0, timed_out: 1'b0, cc: 16'd4, chk: 16'd2, err: 8'd0, ffc: 2'd0});
    step();
    cif.done_req = 1'b0;
    wait_fin(1'b0, edges);
    e = exp_q.pop_front();
    o = obs_a();
    n_checks++;
    if (o !== e) begin
      n_fail++; $display("FAIL mid_fresh_run actual=%h required=%h", o, e);
    end
  endtask

  task automatic test_empty();
    apply_reset();
    cif.start = 1'b1;
    step();
    cif.start    = 1'b0;
    cif.done_req = 1'b1;
    exp_q.push_back('{passed: 1'b0, failed: 1'b1, timed_out: 1'b0, cc: 16'd3, chk: 16'd0, err: 8'd0, ffc: 2'd0});
    step();
    cif.done_req = 1'b0;
    wait_fin(1'b0, edges);
    e = exp_q.pop_front();
    o = obs_a();
    n_checks++;
    if (o !== e) begin
      n_fail++; $display("FAIL empty_verdict actual=%h required=%h", o, e);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_clean_pass();
    test_first_fail();
    test_timeout();
    test_same_cycle();
    test_mid_reset();
    test_empty();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
